pwm_duty_ramp: RTL

//  Soft-start duty-word sequencer upstream of the PWM generator. Captures a target

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_tick_div.sv | 44 ++++
 rtl/pwm_duty_ramp.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty sequencer and the PWM generator.
package pwm_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/pwm_tick_div.sv
// Prescaler for the duty ramp: counts 0..TICK_DIV-1 while enabled and
// emits a single-cycle wrap pulse as the count rolls back to zero.
module pwm_tick_div #(
    parameter int TICK_DIV = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over counting, and a clear also suppresses the wrap pulse.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start duty sequencer: captures a target duty and slews duty_out toward
// it by at most STEP codes, only once a prescaler interval has elapsed and
// only on a PWM period boundary, so the PWM never sees a mid-period change.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int WIDTH    = DUTY_W,
    parameter int TICK_DIV = 256,
    parameter int STEP     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] target_in,
    input  logic             load,
    input  logic             period_end,
    output logic [WIDTH-1:0] duty_out,
    output logic             busy,
    output logic             at_target
);

    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    ramp_state_t      state_q, state_d;
    logic             step_due_q, step_due_d;

    logic             tick_en;
    logic             tick_clr;
    logic             wrap;
    logic             tgt_above;
    logic             tgt_below;
    logic             step_fire;
    logic [WIDTH:0]   gap_up;
    logic [WIDTH:0]   gap_dn;
    logic [WIDTH:0]   amt_up;
    logic [WIDTH:0]   amt_dn;

    pwm_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (tick_clr),
        .wrap  (wrap)
    );

    // Step datapath in WIDTH+1 bits; the step is clamped to the remaining gap so it never overshoots.
    always_comb begin
        tgt_above = (target_q > duty_q);
        tgt_below = (target_q < duty_q);
        gap_up    = {1'b0, target_q} - {1'b0, duty_q};
        gap_dn    = {1'b0, duty_q} - {1'b0, target_q};
        amt_up    = (gap_up < STEP_W) ? gap_up : STEP_W;
        amt_dn    = (gap_dn < STEP_W) ? gap_dn : STEP_W;
    end

    // Direction, prescaler control, pending-step flag and duty update.
    always_comb begin
        target_d   = target_q;
        duty_d     = duty_q;
        state_d    = state_q;
        step_due_d = step_due_q;
        tick_en    = 1'b0;
        tick_clr   = 1'b0;
        step_fire  = 1'b0;
        if (ena) begin
            if (load) begin
                target_d = target_in;
            end
            // Every state moves toward the registered target, so one comparison covers IDLE, UP and DOWN.
            if (tgt_above) begin
                state_d = UP;
            end else if (tgt_below) begin
                state_d = DOWN;
            end else begin
                state_d = IDLE;
            end
            tick_en   = (state_q != IDLE);
            tick_clr  = (state_d == IDLE);
            // A step only moves in the current direction; during the one-cycle lag after a retarget it waits.
            step_fire = step_due_q && period_end &&
                        (((state_q == UP) && tgt_above) || ((state_q == DOWN) && tgt_below));
            if (step_fire) begin
                if (state_q == UP) begin
                    duty_d = WIDTH'({1'b0, duty_q} + amt_up);
                end else begin
                    duty_d = WIDTH'({1'b0, duty_q} - amt_dn);
                end
            end
            if (state_d == IDLE) begin
                step_due_d = 1'b0;
            end else begin
                step_due_d = (step_due_q && !step_fire) || wrap;
            end
        end
    end

    // State registers with synchronous active-low reset; ena=0 holds everything via the _d defaults.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_q   <= '0;
            duty_q     <= '0;
            state_q    <= IDLE;
            step_due_q <= 1'b0;
        end else begin
            target_q   <= target_d;
            duty_q     <= duty_d;
            state_q    <= state_d;
            step_due_q <= step_due_d;
        end
    end

    assign duty_out  = duty_q;
    assign busy      = (state_q != IDLE);
    assign at_target = (duty_q == target_q) && (state_q == IDLE);

endmodule
